// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: digit count, segment type and the active-low glyph set.
// No logic and no latency; the display driver encodes with these same values.
// No backpressure; compile-time constants only.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    // Segment vector ordered {a,b,c,d,e,f,g}, active-low.
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b1100000;
    localparam seg_t SEG_C     = 7'b0110001;
    localparam seg_t SEG_D     = 7'b1000010;
    localparam seg_t SEG_E     = 7'b0110000;
    localparam seg_t SEG_F     = 7'b0111000;
    localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Maps an active-low segment pattern back to its hex nibble, flagging legal glyphs and blank.
// Purely combinational, zero latency.
// No backpressure; output follows input.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] s,
    output logic [3:0] nibble,
    output logic       legal,
    output logic       is_blank
);

    always_comb begin
        nibble   = 4'h0;
        legal    = 1'b1;
        is_blank = 1'b0;
        case (s)
            SEG_0: nibble = 4'h0;
            SEG_1: nibble = 4'h1;
            SEG_2: nibble = 4'h2;
            SEG_3: nibble = 4'h3;
            SEG_4: nibble = 4'h4;
            SEG_5: nibble = 4'h5;
            SEG_6: nibble = 4'h6;
            SEG_7: nibble = 4'h7;
            SEG_8: nibble = 4'h8;
            SEG_9: nibble = 4'h9;
            SEG_A: nibble = 4'hA;
            SEG_B: nibble = 4'hB;
            SEG_C: nibble = 4'hC;
            SEG_D: nibble = 4'hD;
            SEG_E: nibble = 4'hE;
            SEG_F: nibble = 4'hF;
            SEG_BLANK: begin
                legal    = 1'b0;
                is_blank = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Passive receiver for a scanned 7-seg bus: captures settled digits, assembles 8-digit frames, flags faults.
// Capture visible one edge after SETTLE_CYCLES+1 stable sampled edges; frame_valid is a one-cycle pulse.
// No backpressure; the bus is observed only and never stalled.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      CLK100MHZ,
    input  logic                      reset,
    input  logic                      CA,
    input  logic                      CB,
    input  logic                      CC,
    input  logic                      CD,
    input  logic                      CE,
    input  logic                      CF,
    input  logic                      CG,
    input  logic [NUM_DIGITS-1:0]     AN,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic [NUM_DIGITS-1:0]     blank,
    output logic                      frame_valid,
    output logic                      err_multi,
    output logic                      err_code,
    output logic                      timeout
);

    localparam int SW = $clog2(SETTLE_CYCLES + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_HIT = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);

    seg_t                  s_in;
    seg_t                  s_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic [SW-1:0]         stab_cnt;
    logic [TW-1:0]         tmo_cnt;
    logic [NUM_DIGITS-1:0] seen;

    logic                  bus_same;
    logic                  settled;
    logic [NUM_DIGITS-1:0] an_low;
    logic                  an_none;
    logic                  an_multi;
    logic [2:0]            an_idx;
    logic                  capture;
    logic [NUM_DIGITS-1:0] new_seen;
    logic [3:0]            nibble;
    logic                  legal;
    logic                  is_blank;

    assign s_in = {CA, CB, CC, CD, CE, CF, CG};

    // Sampled even during reset so the first post-reset edge already compares against live bus state.
    always_ff @(posedge CLK100MHZ) begin
        an_q <= AN;
        s_q  <= s_in;
    end

    assign bus_same = ({AN, s_in} == {an_q, s_q});
    // Counter saturates one past the hit value, so a held pattern captures exactly once.
    assign settled  = (stab_cnt == SETTLE_HIT);

    assign an_low   = ~an_q;
    assign an_none  = (an_low == '0);
    assign an_multi = |(an_low & (an_low - 1'b1));

    always_comb begin
        an_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_low[i]) an_idx = 3'(i);
        end
    end

    assign capture  = settled && !an_none && !an_multi;
    assign new_seen = seen | (NUM_DIGITS'(1) << an_idx);

    seg7_glyph_decode u_decode (
        .s        (s_q),
        .nibble   (nibble),
        .legal    (legal),
        .is_blank (is_blank)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            stab_cnt    <= '0;
            tmo_cnt     <= '0;
            seen        <= '0;
            digits      <= '0;
            digit_valid <= '0;
            blank       <= '0;
            frame_valid <= 1'b0;
            err_multi   <= 1'b0;
            err_code    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;

            if (!bus_same)
                stab_cnt <= '0;
            else if (stab_cnt != SETTLE_MAX)
                stab_cnt <= stab_cnt + 1'b1;

            if (capture)
                tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (settled && an_multi)
                err_multi <= 1'b1;

            if (capture) begin
                if (legal) begin
                    digits[{an_idx, 2'b00} +: 4] <= nibble;
                    digit_valid[an_idx]          <= 1'b1;
                    blank[an_idx]                <= 1'b0;
                end else if (is_blank) begin
                    digit_valid[an_idx] <= 1'b0;
                    blank[an_idx]       <= 1'b1;
                end else begin
                    digit_valid[an_idx] <= 1'b0;
                    blank[an_idx]       <= 1'b0;
                    err_code            <= 1'b1;
                end

                if (new_seen == '1) begin
                    frame_valid <= 1'b1;
                    seen        <= '0;
                end else begin
                    seen <= new_seen;
                end
            end
        end
    end

    assign timeout = (tmo_cnt == TMO_MAX);

endmodule
